// File: rtl/nn_pkg.sv
// Shared sizing defaults, FSM state encoding and the saturating adder for the output-layer MAC.
// Optional build macro: SATURATE_EN (clamp every accumulator add instead of wrapping).
package nn_pkg;

    localparam int IN_WIDTH  = 8;
    localparam int W_WIDTH   = 8;
    localparam int ACC_WIDTH = 29;
    localparam int N_IN      = 32;
    localparam int N_OUT     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef SATURATE_EN
    // Operands arrive sign-extended from a width-bit accumulator, so the 64-bit sum is exact
    // and only needs clamping back into the signed width-bit range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction
`endif

endpackage

// File: rtl/mac_lane.sv
// One class accumulator: unsigned activation x signed weight MAC, bias add and clear.
// Optional build macro: SATURATE_EN (clamped adds); default build wraps modulo 2^ACC_WIDTH.
module mac_lane import nn_pkg::*; #(
    parameter int IN_WIDTH  = nn_pkg::IN_WIDTH,
    parameter int W_WIDTH   = nn_pkg::W_WIDTH,
    parameter int ACC_WIDTH = nn_pkg::ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        mac_en,
    input  logic                        bias_en,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic signed [W_WIDTH-1:0]   weight,
    input  logic signed [ACC_WIDTH-1:0] bias,
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam int PW = IN_WIDTH + W_WIDTH + 1;

    logic signed [PW-1:0]        act_ext;
    logic signed [PW-1:0]        w_ext;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] addend;
    logic signed [ACC_WIDTH-1:0] next_acc;

    // Activation is zero-extended so 8'hFF multiplies as +255, not -1.
    assign act_ext = $signed({{(PW - IN_WIDTH){1'b0}}, in_data});
    assign w_ext   = PW'(weight);
    assign prod    = act_ext * w_ext;

    always_comb begin
        addend = ACC_WIDTH'(prod);
        if (bias_en) begin
            addend = bias;
        end
    end

`ifdef SATURATE_EN
    assign next_acc = ACC_WIDTH'(sat_add(64'(acc), 64'(addend), ACC_WIDTH));
`else
    assign next_acc = acc + addend;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
        end else if (bias_en || mac_en) begin
            acc <= next_acc;
        end
    end

endmodule

// File: rtl/output_layer_mac.sv
// Logit layer: streams N_IN activations against a per-class weight ROM, adds bias, pulses valid.
// Optional build macro: SATURATE_EN (clamped accumulation inside each mac_lane).
module output_layer_mac import nn_pkg::*; #(
    parameter int IN_WIDTH  = nn_pkg::IN_WIDTH,
    parameter int W_WIDTH   = nn_pkg::W_WIDTH,
    parameter int ACC_WIDTH = nn_pkg::ACC_WIDTH,
    parameter int N_IN      = nn_pkg::N_IN,
    parameter int N_OUT     = nn_pkg::N_OUT,
    localparam int IDX_W    = $clog2(N_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic [IDX_W-1:0]             w_addr,
    input  logic [N_OUT*W_WIDTH-1:0]     weight_bus,
    input  logic [N_OUT*ACC_WIDTH-1:0]   bias_bus,
    output logic [N_OUT*ACC_WIDTH-1:0]   layer_out,
    output logic                         valid,
    output state_t                       fsm_state
);

    // Handshake: a beat transfers on a posedge where in_valid && in_ready; in_ready depends only on state.
    state_t                       state;
    state_t                       state_next;
    logic [IDX_W-1:0]             idx;
    logic                         accept;
    logic                         last_beat;
    logic [N_OUT*ACC_WIDTH-1:0]   acc_flat;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (idx == IDX_W'(N_IN - 1));
    assign w_addr    = idx;
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = last_beat ? BIAS : ACCUM;
            ACCUM:   if (accept && last_beat) state_next = BIAS;
            BIAS:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            valid     <= 1'b0;
            layer_out <= '0;
        end else begin
            state <= state_next;
            valid <= (state == DONE);
            if (state == DONE) begin
                layer_out <= acc_flat;
                idx       <= '0;
            end else if (accept) begin
                idx <= last_beat ? '0 : idx + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        mac_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (state == DONE),
            .mac_en  (accept),
            .bias_en (state == BIAS),
            .in_data (in_data),
            .weight  (weight_bus[j*W_WIDTH +: W_WIDTH]),
            .bias    (bias_bus[j*ACC_WIDTH +: ACC_WIDTH]),
            .acc     (acc_flat[j*ACC_WIDTH +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac: table of frames plus reset and back-to-back sequences.
// A second instance with ACC_WIDTH=16 runs in lockstep to exercise wrap/saturation (SATURATE_EN).
module tb_output_layer_mac;
    import nn_pkg::*;

    localparam int ACC   = 29;
    localparam int ACC16 = 16;
    localparam int NO    = 10;
    localparam int NI    = 32;
    localparam int WW    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 in_valid = 1'b0;
    logic [7:0]           in_data  = '0;
    logic                 in_ready, in_ready16;
    logic [4:0]           w_addr, w_addr16;
    logic [NO*WW-1:0]     weight_bus;
    logic [NO*ACC-1:0]    bias_bus;
    logic [NO*ACC-1:0]    layer_out;
    logic [NO*ACC16-1:0]  bias16 = '0;
    logic [NO*ACC16-1:0]  layer16;
    logic                 valid, valid16;
    state_t               st, st16;

    // Weight ROM model: 0 = same weight on all lanes, 1 = weight*lane, 2 = weight = row index.
    int w_mode   = 0;
    int w_val    = 0;
    int bias_val = 0;

    always_comb begin
        weight_bus = '0;
        bias_bus   = '0;
        for (int j = 0; j < NO; j++) begin
            case (w_mode)
                1:       weight_bus[j*WW +: WW] = WW'(w_val * j);
                2:       weight_bus[j*WW +: WW] = WW'(int'(w_addr));
                default: weight_bus[j*WW +: WW] = WW'(w_val);
            endcase
            bias_bus[j*ACC +: ACC] = ACC'(bias_val);
        end
    end

    output_layer_mac dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_addr(w_addr), .weight_bus(weight_bus), .bias_bus(bias_bus),
        .layer_out(layer_out), .valid(valid), .fsm_state(st)
    );

    output_layer_mac #(.ACC_WIDTH(ACC16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .w_addr(w_addr16), .weight_bus(weight_bus), .bias_bus(bias16),
        .layer_out(layer16), .valid(valid16), .fsm_state(st16)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int addr_bad;
    int vseen;
    int timeouts;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int lane29(input int j);
        return int'($signed(layer_out[j*ACC +: ACC]));
    endfunction

    function automatic int lane16(input int j);
        return int'($signed(layer16[j*ACC16 +: ACC16]));
    endfunction

    // ---------------- driver ----------------
    // Streams nbeats accepted beats; returns just after the edge of the last accept.
    task automatic send_beats(input int nbeats, input bit bubbles);
        int  n = 0;
        int  guard = 0;
        bit  acc_now;
        addr_bad = 0;
        vseen    = 0;
        while (n < nbeats && guard < 2000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            acc_now  = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc_now) begin
                n++;
                if (int'(w_addr) != (n % NI)) addr_bad++;
            end
            if (valid) vseen++;
        end
        in_valid = 1'b0;
        if (n < nbeats) timeouts++;
    endtask

    // Checks the BIAS/DONE latency and the single valid pulse, then the logits.
    task automatic finish_frame(input string name, input int eb, input int es,
                                input int e16b, input int e16s);
        logic [3:0] pat;
        pat[3] = valid;
        check({name, "_ready_low"}, int'(in_ready), 0);
        @(posedge clk); #1; pat[2] = valid;
        @(posedge clk); #1; pat[1] = valid;
        for (int j = 0; j < NO; j++) begin
            check($sformatf("%s_lane%0d", name, j), lane29(j), eb + es * j);
            check($sformatf("%s_acc16_lane%0d", name, j), lane16(j), e16b + e16s * j);
        end
        @(posedge clk); #1; pat[0] = valid;
        check({name, "_valid_pulse"}, int'(pat), 4'b0010);
    endtask

    typedef struct {
        string name;
        int    w_mode;
        int    w_val;
        int    data;
        int    bias;
        bit    bubbles;
        int    exp_base;
        int    exp_step;
        int    e16_base;
        int    e16_step;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e16_neg, e16_pos;
        int acc_cnt, lows, nv, got_v;
        bit held_done;
        rst_n = 1'b0;
        timeouts = 0;

`ifdef SATURATE_EN
        e16_neg = -32768;
        e16_pos = 32767;
`else
        e16_neg = 4096;
        e16_pos = -12256;
`endif
        vecs[0] = '{"all_ones",    0,    1,   1,   0, 1'b0,       32,  0,      32,  0};
        vecs[1] = '{"neg_max",     0, -128, 255,   5, 1'b0, -1044475,  0, e16_neg,  0};
        vecs[2] = '{"bubbles",     0,    1,   1,   0, 1'b1,       32,  0,      32,  0};
        vecs[3] = '{"pos_max",     0,  127, 255,   0, 1'b0,  1036320,  0, e16_pos,  0};
        vecs[4] = '{"lane_scaled", 1,    1,   3, 100, 1'b0,      100, 96,       0, 96};
        vecs[5] = '{"row_weight",  2,    0,   2,   0, 1'b1,      992,  0,     992,  0};
        vecs[6] = '{"neg_bias",    0,   -1,   0,  -7, 1'b0,       -7,  0,       0,  0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_layer_zero", int'(|layer_out), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_state", int'(st), int'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            w_mode   = vecs[i].w_mode;
            w_val    = vecs[i].w_val;
            in_data  = 8'(vecs[i].data);
            bias_val = vecs[i].bias;
            send_beats(NI, vecs[i].bubbles);
            check({vecs[i].name, "_w_addr_track"}, addr_bad, 0);
            check({vecs[i].name, "_no_early_valid"}, vseen, 0);
            finish_frame(vecs[i].name, vecs[i].exp_base, vecs[i].exp_step,
                         vecs[i].e16_base, vecs[i].e16_step);
        end

        // Reset mid-frame: partial sums discarded, layer_out cleared
        w_mode = 0; w_val = 1; in_data = 8'd1; bias_val = 0;
        send_beats(10, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_layer_zero", int'(|layer_out), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_w_addr", int'(w_addr), 0);
        rst_n = 1'b1;
        send_beats(NI, 1'b0);
        check("midrst_no_early_valid", vseen, 0);
        finish_frame("midrst", 32, 0, 32, 0);

        // Back-to-back frames with in_valid held high
        w_mode = 1; w_val = 1; in_data = 8'd1; bias_val = 0;
        in_valid = 1'b1;
        acc_cnt = 0; lows = 0; nv = 0; held_done = 1'b0;
        for (int c = 0; c < 300 && acc_cnt < 2 * NI; c++) begin
            automatic bit rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc_cnt++;
                if (acc_cnt == NI) w_val = 2;
            end else if (acc_cnt == NI) begin
                lows++;
            end
            if (valid) begin
                nv++;
                for (int j = 0; j < NO; j++)
                    check($sformatf("b2b_f1_lane%0d", j), lane29(j), 32 * j);
            end
            if (acc_cnt == 50 && !held_done) begin
                held_done = 1'b1;
                check("b2b_f1_held_lane9", lane29(9), 288);
            end
        end
        in_valid = 1'b0;
        check("b2b_beats_accepted", acc_cnt, 2 * NI);
        check("b2b_ready_gap", lows, 2);
        check("b2b_f1_valid_count", nv, 1);
        got_v = 0;
        for (int c = 0; c < 10 && got_v == 0; c++) begin
            @(posedge clk); #1;
            if (valid) got_v = 1;
        end
        check("b2b_f2_valid_seen", got_v, 1);
        for (int j = 0; j < NO; j++)
            check($sformatf("b2b_f2_lane%0d", j), lane29(j), 64 * j);

        check("beat_timeouts", timeouts, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
